// File: rtl/adc366x_dly_cal.sv
// -----------------------------------------------------------------------------
// adc366x_dly_cal
// Per-lane input-delay calibration for the ADC366x serial (LVDS) interface.
// Each lane's delay tap runs from 0 to 31. At every tap the block loads the
// tap, waits for the delay line to settle, then watches the lane's
// pattern/frame-valid status for a fixed window. The longest run of passing
// taps is the eye. Its centre tap is written back to the lane, and then the
// next lane is calibrated.
//
// Optional feature macro: ADC366X_DLY_CAL_MINEYE_EN
//   defined   : an eye narrower than MIN_EYE taps is treated as a failure
//   undefined : any eye of at least one tap is accepted (MIN_EYE has no effect)
//
// Parameters
//   LANES   : number of lanes to calibrate (4 data + 1 frame, at most 5)
//   SETTLE  : idle cycles after each tap load before checking starts
//   WIN     : check-window length in cycles per tap
//   MIN_EYE : minimum accepted eye width in taps (macro builds only)
//
// Ports
//   clk_i      : configuration clock; all logic runs on its rising edge
//   rst_i      : asynchronous active-high reset
//   start_i    : one-cycle calibration request; ignored while busy
//   lane_ok_i  : per-lane pattern/frame-valid status, already in the clk_i domain
//   cfg_dly_o  : [5k+4:5k] = tap of lane k, [25] = load strobe
//   busy_o     : calibration in progress
//   done_o     : one-cycle pulse when calibration ends
//   err_o      : per-lane failure flags from the last calibration
// -----------------------------------------------------------------------------
module adc366x_dly_cal #(
   parameter int LANES   = 5,
   parameter int SETTLE  = 64,
   parameter int WIN     = 256,
   parameter int MIN_EYE = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [LANES-1:0] lane_ok_i,
   output logic [25:0]      cfg_dly_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [LANES-1:0] err_o
);

   localparam int CNT_MAX = (SETTLE > WIN) ? SETTLE : WIN;
   localparam int CW      = $clog2(CNT_MAX + 4);
   localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
`ifdef ADC366X_DLY_CAL_MINEYE_EN
   localparam int EYE_MIN = (MIN_EYE < 1) ? 1 : MIN_EYE;
`else
   // MIN_EYE has no effect in this build: any non-empty eye is accepted.
   localparam int EYE_MIN = (MIN_EYE > 0) ? 1 : 1;
`endif

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_SETTLE, ST_CHECK, ST_EVAL, ST_CENTER, ST_DONE
   } state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [LW-1:0]    lane_reg, lane_next;
   logic [4:0]       tap_reg, tap_next;
   logic             pass_reg, pass_next;
   logic             run_open_reg, run_open_next;
   logic [4:0]       run_start_reg, run_start_next;
   logic [5:0]       run_len_reg, run_len_next;
   logic [4:0]       best_start_reg, best_start_next;
   logic [5:0]       best_len_reg, best_len_next;
   logic [4:0]       field_reg [LANES];
   logic [4:0]       field_next [LANES];
   logic [LANES-1:0] err_reg, err_next;

   // Run tracking for the tap being evaluated; only consumed in EVAL.
   logic [5:0] ext_len, cl_len, bl_n;
   logic [4:0] ext_start, cl_start, bs_n, centre_tap;
   logic       close_run, eye_bad;

   always_comb begin
      // Extend the open run, or open a new one at this tap.
      ext_len   = run_open_reg ? run_len_reg + 6'd1 : 6'd1;
      ext_start = run_open_reg ? run_start_reg : tap_reg;
      // A fail closes the open run; a pass at tap 31 closes the extended run.
      close_run = pass_reg ? (tap_reg == 5'd31) : run_open_reg;
      cl_len    = pass_reg ? ext_len : run_len_reg;
      cl_start  = pass_reg ? ext_start : run_start_reg;
      // Strictly longer only, so ties keep the lower-tap run.
      if (close_run && (cl_len > best_len_reg)) begin
         bl_n = cl_len;
         bs_n = cl_start;
      end else begin
         bl_n = best_len_reg;
         bs_n = best_start_reg;
      end
      eye_bad    = (bl_n < 6'(EYE_MIN));
      // start + len/2 never exceeds 31, so a 5-bit sum is exact.
      centre_tap = eye_bad ? 5'd0 : bs_n + bl_n[5:1];
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      lane_next       = lane_reg;
      tap_next        = tap_reg;
      pass_next       = pass_reg;
      run_open_next   = run_open_reg;
      run_start_next  = run_start_reg;
      run_len_next    = run_len_reg;
      best_start_next = best_start_reg;
      best_len_next   = best_len_reg;
      field_next      = field_reg;
      err_next        = err_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start_i) begin
               err_next        = '0;
               for (int i = 0; i < LANES; i++) field_next[i] = '0;
               lane_next       = '0;
               tap_next        = '0;
               cnt_next        = '0;
               run_open_next   = 1'b0;
               run_start_next  = '0;
               run_len_next    = '0;
               best_start_next = '0;
               best_len_next   = '0;
               state_next      = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // The field was written on entry; hold the strobe for 4 cycles.
            if (cnt_reg == CW'(3)) begin
               cnt_next   = '0;
               state_next = ST_SETTLE;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_SETTLE: begin
            if (cnt_reg == CW'(SETTLE - 1)) begin
               cnt_next   = '0;
               pass_next  = 1'b1;
               state_next = ST_CHECK;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_CHECK: begin
            pass_next = pass_reg & lane_ok_i[lane_reg];
            if (cnt_reg == CW'(WIN - 1)) begin
               cnt_next   = '0;
               state_next = ST_EVAL;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_EVAL: begin
            run_open_next   = pass_reg && (tap_reg != 5'd31);
            run_start_next  = ext_start;
            run_len_next    = pass_reg ? ext_len : 6'd0;
            best_start_next = bs_n;
            best_len_next   = bl_n;
            if (tap_reg != 5'd31) begin
               tap_next             = tap_reg + 5'd1;
               field_next[lane_reg] = tap_reg + 5'd1;
               state_next           = ST_LOAD;
            end else begin
               field_next[lane_reg] = centre_tap;
               err_next[lane_reg]   = eye_bad;
               state_next           = ST_CENTER;
            end
         end
         ST_CENTER: begin
            if (cnt_reg == CW'(3)) begin
               cnt_next = '0;
               if (lane_reg == LW'(LANES - 1)) begin
                  state_next = ST_DONE;
               end else begin
                  // The next lane's field is still 0 from the start request.
                  lane_next       = lane_reg + LW'(1);
                  tap_next        = '0;
                  run_open_next   = 1'b0;
                  run_start_next  = '0;
                  run_len_next    = '0;
                  best_start_next = '0;
                  best_len_next   = '0;
                  state_next      = ST_LOAD;
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         lane_reg       <= '0;
         tap_reg        <= '0;
         pass_reg       <= 1'b0;
         run_open_reg   <= 1'b0;
         run_start_reg  <= '0;
         run_len_reg    <= '0;
         best_start_reg <= '0;
         best_len_reg   <= '0;
         err_reg        <= '0;
         for (int i = 0; i < LANES; i++) field_reg[i] <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         lane_reg       <= lane_next;
         tap_reg        <= tap_next;
         pass_reg       <= pass_next;
         run_open_reg   <= run_open_next;
         run_start_reg  <= run_start_next;
         run_len_reg    <= run_len_next;
         best_start_reg <= best_start_next;
         best_len_reg   <= best_len_next;
         err_reg        <= err_next;
         field_reg      <= field_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_field
         if (gi < LANES) begin : g_used
            assign cfg_dly_o[5*gi +: 5] = field_reg[gi];
         end else begin : g_unused
            assign cfg_dly_o[5*gi +: 5] = 5'd0;
         end
      end
   endgenerate

   assign cfg_dly_o[25] = (state_reg == ST_LOAD) || (state_reg == ST_CENTER);
   assign busy_o        = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
   assign done_o        = (state_reg == ST_DONE);
   assign err_o         = err_reg;

endmodule
